// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - IF-stage direct-mapped branch direction/target predictor
//
// Purpose:
//   Combinational, zero-latency lookup of a direct-mapped table that returns
//   a taken/not-taken estimate and a predicted target for the fetch PC.
//   The table is trained from EX-stage branch resolution. Each entry holds
//   {valid, tag, 2-bit saturating counter, 32-bit target}.
//   The table is built from flops, and reset clears every entry.
//
// Optional feature (macro BRANCH_PREDICTOR_PERF_EN):
//   defined   - 32-bit wrapping counters for resolved branches and mispredicts
//   undefined - perf ports are tied to zero and no counter flops exist
//
// Ports:
//   clk                      in   1   system clock, rising edge
//   reset                    in   1   asynchronous, active-high, clears all state
//   if_pc                    in   32  fetch PC being looked up (bits [1:0] ignored)
//   branch_estimation        out  1   predicted taken for if_pc
//   branch_target_predicted  out  32  predicted target, 0 when not predicted taken
//   ex_branch                in   1   update strobe: conditional branch resolved in EX
//   ex_pc                    in   32  PC of the resolving branch
//   ex_branch_taken          in   1   actual outcome
//   ex_branch_target         in   32  actual target
//   ex_prediction_miss       in   1   EX mispredict flag (perf counters only)
//   perf_branch_count        out  32  resolved-branch counter
//   perf_miss_count          out  32  mispredict counter

module branch_predictor #(
   parameter int INDEX_BITS = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] if_pc,
   output logic        branch_estimation,
   output logic [31:0] branch_target_predicted,
   input  logic        ex_branch,
   input  logic [31:0] ex_pc,
   input  logic        ex_branch_taken,
   input  logic [31:0] ex_branch_target,
   input  logic        ex_prediction_miss,
   output logic [31:0] perf_branch_count,
   output logic [31:0] perf_miss_count
);

   localparam int TAG_BITS = 30 - INDEX_BITS;
   localparam int ENTRIES  = 1 << INDEX_BITS;

   localparam logic [1:0] CTR_RESET       = 2'b01;
   localparam logic [1:0] CTR_WEAK_TAKEN  = 2'b10;
   localparam logic [1:0] CTR_MAX         = 2'b11;
   localparam logic [1:0] CTR_MIN         = 2'b00;

   // Table storage
   logic                valid_q  [ENTRIES];
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [1:0]          ctr_q    [ENTRIES];
   logic [31:0]         target_q [ENTRIES];

   // Lookup path (purely combinational, reads pre-update state)
   logic [INDEX_BITS-1:0] rd_idx;
   logic [TAG_BITS-1:0]   rd_tag;
   logic                  rd_hit;

   assign rd_idx = if_pc[INDEX_BITS+1:2];
   assign rd_tag = if_pc[31:INDEX_BITS+2];
   assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

   assign branch_estimation       = rd_hit && ctr_q[rd_idx][1];
   assign branch_target_predicted = branch_estimation ? target_q[rd_idx] : 32'b0;

   // Update path: compute the next contents of the single entry addressed by
   // ex_pc, then commit it on the clock edge when wr_en is set.
   logic [INDEX_BITS-1:0] wr_idx;
   logic [TAG_BITS-1:0]   wr_tag;
   logic                  wr_hit;
   logic                  wr_en;
   logic                  wr_valid_n;
   logic [TAG_BITS-1:0]   wr_tag_n;
   logic [1:0]            wr_ctr_n;
   logic [31:0]           wr_target_n;

   assign wr_idx = ex_pc[INDEX_BITS+1:2];
   assign wr_tag = ex_pc[31:INDEX_BITS+2];
   assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

   always_comb begin
      wr_en       = 1'b0;
      wr_valid_n  = valid_q[wr_idx];
      wr_tag_n    = tag_q[wr_idx];
      wr_ctr_n    = ctr_q[wr_idx];
      wr_target_n = target_q[wr_idx];
      if (ex_branch) begin
         if (wr_hit) begin
            wr_en = 1'b1;
            if (ex_branch_taken) begin
               wr_ctr_n    = (ctr_q[wr_idx] == CTR_MAX) ? CTR_MAX : ctr_q[wr_idx] + 2'd1;
               wr_target_n = ex_branch_target;
            end else begin
               wr_ctr_n    = (ctr_q[wr_idx] == CTR_MIN) ? CTR_MIN : ctr_q[wr_idx] - 2'd1;
            end
         end else if (ex_branch_taken) begin
            // Allocate on a taken miss, evicting whatever occupied the slot.
            // A not-taken miss leaves the table alone.
            wr_en       = 1'b1;
            wr_valid_n  = 1'b1;
            wr_tag_n    = wr_tag;
            wr_ctr_n    = CTR_WEAK_TAKEN;
            wr_target_n = ex_branch_target;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            ctr_q[i]    <= CTR_RESET;
            target_q[i] <= 32'b0;
         end
      end else if (wr_en) begin
         valid_q[wr_idx]  <= wr_valid_n;
         tag_q[wr_idx]    <= wr_tag_n;
         ctr_q[wr_idx]    <= wr_ctr_n;
         target_q[wr_idx] <= wr_target_n;
      end
   end

`ifdef BRANCH_PREDICTOR_PERF_EN
   logic [31:0] perf_branch_q;
   logic [31:0] perf_miss_q;

   // Plain 32-bit adders; wrap from 0xFFFFFFFF to 0 naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_branch_q <= 32'b0;
         perf_miss_q   <= 32'b0;
      end else if (ex_branch) begin
         perf_branch_q <= perf_branch_q + 32'd1;
         if (ex_prediction_miss) begin
            perf_miss_q <= perf_miss_q + 32'd1;
         end
      end
   end

   assign perf_branch_count = perf_branch_q;
   assign perf_miss_count   = perf_miss_q;

   logic unused_pc_bits;
   assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};
`else
   assign perf_branch_count = 32'b0;
   assign perf_miss_count   = 32'b0;

   logic unused_pc_bits;
   assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0], ex_prediction_miss};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor

module tb_branch_predictor;

   logic        clk;
   logic        reset;
   logic [31:0] if_pc;
   logic        branch_estimation;
   logic [31:0] branch_target_predicted;
   logic        ex_branch;
   logic [31:0] ex_pc;
   logic        ex_branch_taken;
   logic [31:0] ex_branch_target;
   logic        ex_prediction_miss;
   logic [31:0] perf_branch_count;
   logic [31:0] perf_miss_count;

   int vectors;
   int miscompares;

   branch_predictor dut (
      .clk                     (clk),
      .reset                   (reset),
      .if_pc                   (if_pc),
      .branch_estimation       (branch_estimation),
      .branch_target_predicted (branch_target_predicted),
      .ex_branch               (ex_branch),
      .ex_pc                   (ex_pc),
      .ex_branch_taken         (ex_branch_taken),
      .ex_branch_target        (ex_branch_target),
      .ex_prediction_miss      (ex_prediction_miss),
      .perf_branch_count       (perf_branch_count),
      .perf_miss_count         (perf_miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One update edge; inputs change 1ns after the edge, away from sampling.
   task automatic do_update(input logic [31:0] pc, input logic taken,
                            input logic [31:0] tgt, input logic miss);
      ex_branch          = 1'b1;
      ex_pc              = pc;
      ex_branch_taken    = taken;
      ex_branch_target   = tgt;
      ex_prediction_miss = miss;
      @(posedge clk);
      #1;
      ex_branch          = 1'b0;
      ex_prediction_miss = 1'b0;
   endtask

   task automatic probe(input logic [31:0] pc);
      if_pc = pc;
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      ex_branch = 0; ex_pc = 0; ex_branch_taken = 0; ex_branch_target = 0;
      ex_prediction_miss = 0; if_pc = 32'h100;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      probe(32'h100);
      vectors++;
      if (branch_estimation !== 1'b0 || branch_target_predicted !== 32'h0) begin
         $display("FAIL reset_lookup est=%b tgt=%h want est=0 tgt=00000000", branch_estimation, branch_target_predicted);
         miscompares++;
      end
      vectors++;
      if (perf_branch_count !== 32'h0 || perf_miss_count !== 32'h0) begin
         $display("FAIL reset_perf br=%h miss=%h want 0/0", perf_branch_count, perf_miss_count);
         miscompares++;
      end
   endtask

   task automatic test_allocate();
      pulse_reset();
      if_pc              = 32'h100;
      ex_branch          = 1'b1;
      ex_pc              = 32'h100;
      ex_branch_taken    = 1'b1;
      ex_branch_target   = 32'h80;
      #1;
      vectors++;
      if (branch_estimation !== 1'b0) begin
         $display("FAIL alloc_same_cycle est=%b want 0", branch_estimation);
         miscompares++;
      end
      @(posedge clk);
      #1;
      ex_branch = 1'b0;
      probe(32'h100);
      vectors++;
      if (branch_estimation !== 1'b1 || branch_target_predicted !== 32'h80) begin
         $display("FAIL alloc_next est=%b tgt=%h want est=1 tgt=00000080", branch_estimation, branch_target_predicted);
         miscompares++;
      end
      probe(32'h102);
      vectors++;
      if (branch_estimation !== 1'b1 || branch_target_predicted !== 32'h80) begin
         $display("FAIL low_bits_ignored est=%b tgt=%h want est=1 tgt=00000080", branch_estimation, branch_target_predicted);
         miscompares++;
      end
      probe(32'h104);
      vectors++;
      if (branch_estimation !== 1'b0 || branch_target_predicted !== 32'h0) begin
         $display("FAIL neighbour_idx est=%b tgt=%h want est=0 tgt=00000000", branch_estimation, branch_target_predicted);
         miscompares++;
      end
   endtask

   task automatic test_saturation();
      pulse_reset();
      do_update(32'h100, 1'b1, 32'h80, 1'b0);   // ctr 10
      do_update(32'h100, 1'b1, 32'h84, 1'b0);   // ctr 11
      do_update(32'h100, 1'b1, 32'h88, 1'b0);   // stays 11
      do_update(32'h100, 1'b0, 32'h0,  1'b0);   // 10
      probe(32'h100);
      vectors++;
      if (branch_estimation !== 1'b1 || branch_target_predicted !== 32'h88) begin
         $display("FAIL sat_high est=%b tgt=%h want est=1 tgt=00000088", branch_estimation, branch_target_predicted);
         miscompares++;
      end
      do_update(32'h100, 1'b0, 32'h0, 1'b0);    // 01
      probe(32'h100);
      vectors++;
      if (branch_estimation !== 1'b0 || branch_target_predicted !== 32'h0) begin
         $display("FAIL weak_nt est=%b tgt=%h want est=0 tgt=00000000", branch_estimation, branch_target_predicted);
         miscompares++;
      end
      do_update(32'h100, 1'b0, 32'h0, 1'b0);    // 00
      do_update(32'h100, 1'b0, 32'h0, 1'b0);    // stays 00
      do_update(32'h100, 1'b1, 32'h90, 1'b0);   // 01
      probe(32'h100);
      vectors++;
      if (branch_estimation !== 1'b0 || branch_target_predicted !== 32'h0) begin
         $display("FAIL sat_low est=%b tgt=%h want est=0 tgt=00000000", branch_estimation, branch_target_predicted);
         miscompares++;
      end
      do_update(32'h100, 1'b1, 32'h94, 1'b0);   // 10
      probe(32'h100);
      vectors++;
      if (branch_estimation !== 1'b1 || branch_target_predicted !== 32'h94) begin
         $display("FAIL recover est=%b tgt=%h want est=1 tgt=00000094", branch_estimation, branch_target_predicted);
         miscompares++;
      end
   endtask

   task automatic test_alias();
      pulse_reset();
      do_update(32'h100, 1'b1, 32'h80, 1'b0);
      do_update(32'h200, 1'b0, 32'h0,  1'b0);
      probe(32'h100);
      vectors++;
      if (branch_estimation !== 1'b1 || branch_target_predicted !== 32'h80) begin
         $display("FAIL alias_nt_keep est=%b tgt=%h want est=1 tgt=00000080", branch_estimation, branch_target_predicted);
         miscompares++;
      end
      probe(32'h200);
      vectors++;
      if (branch_estimation !== 1'b0) begin
         $display("FAIL alias_tag_check est=%b want 0", branch_estimation);
         miscompares++;
      end
      do_update(32'h200, 1'b1, 32'h40, 1'b0);
      probe(32'h100);
      vectors++;
      if (branch_estimation !== 1'b0 || branch_target_predicted !== 32'h0) begin
         $display("FAIL alias_evict est=%b tgt=%h want est=0 tgt=00000000", branch_estimation, branch_target_predicted);
         miscompares++;
      end
      probe(32'h200);
      vectors++;
      if (branch_estimation !== 1'b1 || branch_target_predicted !== 32'h40) begin
         $display("FAIL alias_new est=%b tgt=%h want est=1 tgt=00000040", branch_estimation, branch_target_predicted);
         miscompares++;
      end
   endtask

   task automatic test_no_alloc();
      pulse_reset();
      do_update(32'h300, 1'b0, 32'h1234, 1'b0);
      do_update(32'h300, 1'b1, 32'h50, 1'b0);   // would be 11 if NT had allocated at 10
      do_update(32'h300, 1'b0, 32'h0,  1'b0);   // 10 -> 01 : predicts not taken
      probe(32'h300);
      vectors++;
      if (branch_estimation !== 1'b0 || branch_target_predicted !== 32'h0) begin
         $display("FAIL no_alloc est=%b tgt=%h want est=0 tgt=00000000", branch_estimation, branch_target_predicted);
         miscompares++;
      end
   endtask

   task automatic test_idle();
      pulse_reset();
      do_update(32'h100, 1'b1, 32'h80, 1'b0);
      ex_branch        = 1'b0;
      ex_pc            = 32'h100;
      ex_branch_taken  = 1'b0;
      ex_branch_target = 32'hDEAD;
      repeat (3) @(posedge clk);
      ex_pc = 32'h400; ex_branch_taken = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      probe(32'h100);
      vectors++;
      if (branch_estimation !== 1'b1 || branch_target_predicted !== 32'h80) begin
         $display("FAIL idle_hold est=%b tgt=%h want est=1 tgt=00000080", branch_estimation, branch_target_predicted);
         miscompares++;
      end
      probe(32'h400);
      vectors++;
      if (branch_estimation !== 1'b0) begin
         $display("FAIL idle_no_alloc est=%b want 0", branch_estimation);
         miscompares++;
      end
   endtask

   task automatic test_back_to_back();
      pulse_reset();
      ex_branch = 1'b1; ex_pc = 32'h100; ex_branch_taken = 1'b1; ex_branch_target = 32'h80;
      @(posedge clk); #1;                       // alloc 10
      ex_branch_target = 32'h90;
      @(posedge clk); #1;                       // 11, tgt 90
      ex_branch_taken = 1'b0; ex_branch_target = 32'h0;
      @(posedge clk); #1;                       // 10
      ex_branch = 1'b0;
      probe(32'h100);
      vectors++;
      if (branch_estimation !== 1'b1 || branch_target_predicted !== 32'h90) begin
         $display("FAIL b2b_1 est=%b tgt=%h want est=1 tgt=00000090", branch_estimation, branch_target_predicted);
         miscompares++;
      end
      ex_branch = 1'b1;
      @(posedge clk); #1;                       // 01
      ex_branch = 1'b0;
      probe(32'h100);
      vectors++;
      if (branch_estimation !== 1'b0 || branch_target_predicted !== 32'h0) begin
         $display("FAIL b2b_2 est=%b tgt=%h want est=0 tgt=00000000", branch_estimation, branch_target_predicted);
         miscompares++;
      end
   endtask

   task automatic test_async_reset();
      pulse_reset();
      do_update(32'h100, 1'b1, 32'h80, 1'b0);
      probe(32'h100);
      #2;
      reset = 1'b1;
      #1;
      vectors++;
      if (branch_estimation !== 1'b0 || branch_target_predicted !== 32'h0) begin
         $display("FAIL async_reset est=%b tgt=%h want est=0 tgt=00000000", branch_estimation, branch_target_predicted);
         miscompares++;
      end
      // Update presented while reset is high is lost.
      ex_branch = 1'b1; ex_pc = 32'h500; ex_branch_taken = 1'b1; ex_branch_target = 32'h70;
      @(posedge clk); #1;
      ex_branch = 1'b0;
      reset = 1'b0;
      probe(32'h500);
      vectors++;
      if (branch_estimation !== 1'b0) begin
         $display("FAIL update_in_reset est=%b want 0", branch_estimation);
         miscompares++;
      end
      do_update(32'h500, 1'b1, 32'h70, 1'b0);
      probe(32'h500);
      vectors++;
      if (branch_estimation !== 1'b1 || branch_target_predicted !== 32'h70) begin
         $display("FAIL post_reset_update est=%b tgt=%h want est=1 tgt=00000070", branch_estimation, branch_target_predicted);
         miscompares++;
      end
   endtask

   task automatic test_perf();
      pulse_reset();
      do_update(32'h100, 1'b1, 32'h80, 1'b1);
      do_update(32'h104, 1'b0, 32'h0,  1'b0);
      do_update(32'h100, 1'b0, 32'h0,  1'b1);
      do_update(32'h108, 1'b1, 32'h20, 1'b0);
      do_update(32'h100, 1'b1, 32'h80, 1'b0);
      ex_prediction_miss = 1'b1;                // miss with no strobe must not count
      @(posedge clk); #1;
      ex_prediction_miss = 1'b0;
`ifdef BRANCH_PREDICTOR_PERF_EN
      vectors++;
      if (perf_branch_count !== 32'd5 || perf_miss_count !== 32'd2) begin
         $display("FAIL perf_count br=%0d miss=%0d want 5/2", perf_branch_count, perf_miss_count);
         miscompares++;
      end
      force dut.perf_branch_q = 32'hFFFFFFFF;
      force dut.perf_miss_q   = 32'hFFFFFFFF;
      #1;
      release dut.perf_branch_q;
      release dut.perf_miss_q;
      do_update(32'h100, 1'b1, 32'h80, 1'b1);
      vectors++;
      if (perf_branch_count !== 32'h0 || perf_miss_count !== 32'h0) begin
         $display("FAIL perf_wrap br=%h miss=%h want 0/0", perf_branch_count, perf_miss_count);
         miscompares++;
      end
`else
      vectors++;
      if (perf_branch_count !== 32'h0 || perf_miss_count !== 32'h0) begin
         $display("FAIL perf_tied br=%h miss=%h want 0/0", perf_branch_count, perf_miss_count);
         miscompares++;
      end
`endif
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_allocate();
      test_saturation();
      test_alias();
      test_no_alloc();
      test_idle();
      test_back_to_back();
      test_async_reset();
      test_perf();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
